// File: rtl/key_select_ctrl.sv
// Debounced four-key front end producing a latched active-low one-hot mode code.
// Optional LONG_PRESS_CLR_EN: holding the selected key for LONG_MAX cycles clears the selection.
module key_select_ctrl #(
  parameter int unsigned CNT_DB   = 1_000_000,
  parameter int unsigned LONG_MAX = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] key_stable
);

  if (CNT_DB < 2 || CNT_DB > 2**20 || LONG_MAX < 2 || LONG_MAX > 2**27) begin : g_bad_param
    $error("key_select_ctrl: CNT_DB or LONG_MAX out of range");
  end

  localparam logic [19:0] DB_LAST = 20'(CNT_DB - 1);

  logic [3:0]  sync1, sync2;
  logic [3:0]  key_stable_d;
  logic [19:0] db_cnt [4];
  logic [3:0]  press;
  logic        press_any;
  logic [1:0]  press_idx;
  logic [3:0]  code_next;
  logic        lp_fire;

  assign press     = key_stable_d & ~key_stable;
  assign press_any = |press;

  // Lowest asserted index wins when several keys land on the same cycle.
  always_comb begin
    press_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (press[i]) press_idx = 2'(i);
    end
  end

  assign code_next = key_code[press_idx] ? ~(4'b0001 << press_idx) : 4'b1111;

`ifdef LONG_PRESS_CLR_EN
  localparam logic [26:0] LP_LAST = 27'(LONG_MAX - 1);

  logic [26:0] lp_cnt;
  logic        held_sel;

  assign held_sel = |(~key_code & ~key_stable);
  assign lp_fire  = held_sel && (lp_cnt == LP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_cnt <= '0;
    end else if (!held_sel || press_any || lp_fire) begin
      lp_cnt <= '0;
    end else begin
      lp_cnt <= lp_cnt + 27'd1;
    end
  end
`else
  assign lp_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1        <= '1;
      sync2        <= '1;
      key_stable   <= '1;
      key_stable_d <= '1;
      key_code     <= '1;
      key_valid    <= 1'b0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1        <= key_in;
      sync2        <= sync1;
      key_stable_d <= key_stable;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == key_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          key_stable[i] <= sync2[i];
          db_cnt[i]     <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
      // A long-press clear overrides a coincident toggle; either way one pulse.
      key_valid <= press_any | lp_fire;
      if (lp_fire) begin
        key_code <= 4'b1111;
      end else if (press_any) begin
        key_code <= code_next;
      end
    end
  end

endmodule

// File: tb/tb_key_select_ctrl.sv
// Self-checking bench for key_select_ctrl with CNT_DB=4, LONG_MAX=32.
module tb_key_select_ctrl;

  localparam int CNT_DB   = 4;
  localparam int LONG_MAX = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = 4'b1111;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] key_stable;

  int n_total = 0;
  int n_pass  = 0;

  key_select_ctrl #(.CNT_DB(CNT_DB), .LONG_MAX(LONG_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_stable (key_stable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  function automatic logic legal_code(input logic [3:0] c);
    return (c == 4'b1111) || (c == 4'b1110) || (c == 4'b1101) ||
           (c == 4'b1011) || (c == 4'b0111);
  endfunction

  // Reference model: raw samples reach the debouncer two edges late; a key's
  // level flips once the last CNT_DB samples all disagree with it.
  logic [3:0] m_pipe [2];
  logic [3:0] m_win [$];
  logic [3:0] m_stable, m_code, m_pend;
  logic       m_valid;
  int         m_hold;

  function automatic void model_reset();
    m_pipe[0] = 4'b1111;
    m_pipe[1] = 4'b1111;
    m_win.delete();
    for (int k = 0; k < CNT_DB; k++) m_win.push_back(4'b1111);
    m_stable = 4'b1111;
    m_code   = 4'b1111;
    m_pend   = 4'b0000;
    m_valid  = 1'b0;
    m_hold   = 0;
  endfunction

  function automatic void model_step(input logic [3:0] x);
    logic [3:0] s2, old_stable;
    bit held, fire, all_diff;
    int j;
    held = 0;
    for (int i = 0; i < 4; i++) if (m_code[i] == 1'b0 && m_stable[i] == 1'b0) held = 1;
    fire = 0;
`ifdef LONG_PRESS_CLR_EN
    fire = held && (m_hold == LONG_MAX - 1);
`endif
    m_valid = fire || (m_pend != 0);
    if (fire) begin
      m_code = 4'b1111;
    end else if (m_pend != 0) begin
      j = 0;
      while (!m_pend[j]) j++;
      if (m_code[j] == 1'b0) m_code = 4'b1111;
      else begin
        m_code = 4'b1111;
        m_code[j] = 1'b0;
      end
    end
    if (!held || fire || m_pend != 0) m_hold = 0;
    else m_hold++;

    s2 = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = x;
    m_win.push_back(s2);
    void'(m_win.pop_front());
    old_stable = m_stable;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1;
      foreach (m_win[k]) if (m_win[k][i] == m_stable[i]) all_diff = 0;
      if (all_diff) m_stable[i] = ~m_stable[i];
    end
    m_pend = old_stable & ~m_stable;
  endfunction

  typedef struct {
    logic [3:0] keys;
    int         cycles;
    logic [3:0] exp_code;
    int         exp_pulses;
    logic       chk_stb;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int pulses;
    logic [3:0] rk;

    tbl[0]  = '{4'b1111, 50, 4'b1111, 0, 1'b1};
    tbl[1]  = '{4'b1110, 10, 4'b1110, 1, 1'b1};
    tbl[2]  = '{4'b1111, 10, 4'b1110, 0, 1'b1};
    tbl[3]  = '{4'b1101,  3, 4'b1110, 0, 1'b0};
    tbl[4]  = '{4'b1111,  1, 4'b1110, 0, 1'b0};
    tbl[5]  = '{4'b1101,  3, 4'b1110, 0, 1'b0};
    tbl[6]  = '{4'b1111, 10, 4'b1110, 0, 1'b1};
    tbl[7]  = '{4'b1011, 10, 4'b1011, 1, 1'b1};
    tbl[8]  = '{4'b1111, 10, 4'b1011, 0, 1'b1};
    tbl[9]  = '{4'b1011, 10, 4'b1111, 1, 1'b1};
    tbl[10] = '{4'b1111, 10, 4'b1111, 0, 1'b1};
    tbl[11] = '{4'b0101, 10, 4'b1101, 1, 1'b1};
    tbl[12] = '{4'b1111, 10, 4'b1101, 0, 1'b1};
    tbl[13] = '{4'b0111, 10, 4'b0111, 1, 1'b1};
    tbl[14] = '{4'b1111, 10, 4'b0111, 0, 1'b1};
    tbl[15] = '{4'b1110, 10, 4'b1110, 1, 1'b1};
    tbl[16] = '{4'b1111, 10, 4'b1110, 0, 1'b1};

    #1;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("reset_code", key_code, 4'b1111);
    chk("reset_stable", key_stable, 4'b1111);
    chk("reset_valid", key_valid, 1'b0);

    foreach (tbl[v]) begin
      key_in = tbl[v].keys;
      pulses = 0;
      for (int c = 0; c < tbl[v].cycles; c++) begin
        tick();
        if (key_valid) pulses++;
      end
      chk($sformatf("tbl%0d_code", v), key_code, tbl[v].exp_code);
      chk($sformatf("tbl%0d_pulses", v), pulses, tbl[v].exp_pulses);
      if (tbl[v].chk_stb) chk($sformatf("tbl%0d_stable", v), key_stable, tbl[v].keys);
    end

    // Exact press latency from the driving edge.
    do_reset();
    key_in = 4'b1110;
    repeat (5) tick();
    chk("lat_stable_n5", key_stable, 4'b1111);
    tick();
    chk("lat_stable_n6", key_stable, 4'b1110);
    chk("lat_code_n6", key_code, 4'b1111);
    chk("lat_valid_n6", key_valid, 1'b0);
    tick();
    chk("lat_code_n7", key_code, 4'b1110);
    chk("lat_valid_n7", key_valid, 1'b1);
    tick();
    chk("lat_valid_n8", key_valid, 1'b0);
    key_in = 4'b1111;
    repeat (10) tick();

    // Reset pulse while key 3 is held.
    key_in = 4'b0111;
    repeat (12) tick();
    chk("rst_pre_code", key_code, 4'b0111);
    rst_n = 1'b0;
    #1;
    chk("rst_async_code", key_code, 4'b1111);
    chk("rst_async_stable", key_stable, 4'b1111);
    tick();
    tick();
    chk("rst_hold_code", key_code, 4'b1111);
    chk("rst_hold_valid", key_valid, 1'b0);
    rst_n = 1'b1;
    repeat (6) tick();
    chk("rst_rel6_code", key_code, 4'b1111);
    chk("rst_rel6_stable", key_stable, 4'b0111);
    tick();
    chk("rst_rel7_code", key_code, 4'b0111);
    chk("rst_rel7_valid", key_valid, 1'b1);
    key_in = 4'b1111;
    repeat (10) tick();

    // Long hold of key 0 for 60 cycles.
    do_reset();
    key_in = 4'b1110;
    pulses = 0;
    repeat (7) tick();
    if (key_valid) pulses++;
    chk("lp_sel_code", key_code, 4'b1110);
    repeat (31) begin
      tick();
      if (key_valid) pulses++;
    end
    chk("lp_s31_code", key_code, 4'b1110);
    tick();
    if (key_valid) pulses++;
`ifdef LONG_PRESS_CLR_EN
    chk("lp_s32_code", key_code, 4'b1111);
    chk("lp_s32_valid", key_valid, 1'b1);
`else
    chk("lp_s32_code", key_code, 4'b1110);
    chk("lp_s32_valid", key_valid, 1'b0);
`endif
    repeat (21) begin
      tick();
      if (key_valid) pulses++;
    end
`ifdef LONG_PRESS_CLR_EN
    chk("lp_end_code", key_code, 4'b1111);
    chk("lp_pulses", pulses, 2);
`else
    chk("lp_end_code", key_code, 4'b1110);
    chk("lp_pulses", pulses, 1);
`endif
    key_in = 4'b1111;
    repeat (10) tick();

    // Randomised segments against the reference model.
    do_reset();
    model_reset();
    for (int s = 0; s < 160; s++) begin
      int len;
      case ($urandom_range(0, 5))
        0, 1:    rk = 4'b1111;
        2, 3:    begin rk = 4'b1111; rk[$urandom_range(0, 3)] = 1'b0; end
        4:       rk = 4'($urandom_range(0, 15));
        default: rk = 4'b1111;
      endcase
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 45) : $urandom_range(1, 14);
      key_in = rk;
      for (int c = 0; c < len; c++) begin
        tick();
        model_step(rk);
        chk("rnd_stable", key_stable, m_stable);
        chk("rnd_code", key_code, m_code);
        chk("rnd_valid", key_valid, m_valid);
        chk("rnd_legal", legal_code(key_code), 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
